instr_fetch_unit: RTL

Instruction-fetch front end feeding the single-cycle Datapath/ControlUnit pair. Holds the program counter and a loadable instruction memory. Presents one 16-bit instruction per cycle (4-bit opcode in [15:12]) and computes next-PC from the datapath's branch decision. A small run-control FSM handles program load, start and halt.

---
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: program counter, loadable instruction memory with
// zero-latency read, and IDLE/RUN/HALT run control for a single-cycle datapath.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter logic [3:0]  HALT_OP  = 4'hF,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              LoadValid,
    output logic              LoadReady,
    input  logic [ADDR_W-2:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              BranchTaken,
    input  logic [15:0]       BranchImm,
    output logic [DATA_W-1:0] Instruction,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus2,
    output logic              InstrValid,
    output logic              Halted,
    output logic [15:0]       RetiredCount
);

    localparam int unsigned Depth = 2 ** (ADDR_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         retired_q, retired_d;
    logic [DATA_W-1:0]   mem [Depth];
    logic [DATA_W-1:0]   fetched;
    logic [ADDR_W-1:0]   pc_plus2;
    logic [ADDR_W-1:0]   imm_bytes;
    logic [ADDR_W-1:0]   branch_target;
    logic                is_halt;
    logic                load_en;

    assign fetched  = mem[pc_q[ADDR_W-1:1]];
    assign is_halt  = (fetched[DATA_W-1 -: 4] == HALT_OP);
    assign pc_plus2 = pc_q + ADDR_W'(2);

    // Word offset becomes a byte offset; the sign-extending cast keeps wide PCs correct.
    assign imm_bytes     = ADDR_W'($signed({BranchImm, 1'b0}));
    assign branch_target = pc_plus2 + imm_bytes;

    assign load_en      = LoadValid & LoadReady;
    assign PC           = pc_q;
    assign PCPlus2      = pc_plus2;
    assign RetiredCount = retired_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        LoadReady   = 1'b1;
        InstrValid  = 1'b0;
        Halted      = 1'b0;
        Instruction = NOP_WORD;
        unique case (state_q)
            StIdle, StHalt: begin
                Halted = (state_q == StHalt);
                if (Start) begin
                    state_d   = StRun;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            StRun: begin
                LoadReady   = 1'b0;
                InstrValid  = 1'b1;
                Instruction = fetched;
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                // The halt instruction retires but leaves PC pointing at itself.
                if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    pc_d = BranchTaken ? branch_target : pc_plus2;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // Program memory survives reset, so it has no reset branch.
    always_ff @(posedge Clock) begin
        if (load_en) begin
            mem[LoadAddr] <= LoadData;
        end
    end

endmodule
